// File: rtl/sub_bytes_unit_if.sv
// Block-level ports of the SubBytes engine: one input channel carrying the AES
// state in, one output channel carrying the substituted state back out.
interface sub_bytes_unit_if;
    // Both channels use valid/ready: a transfer completes on a rising edge where
    // valid and ready are both high. The source keeps valid and its payload steady
    // until that edge, and ready never waits on valid.
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;

    modport master (
        output in_valid,
        output in_state,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_state
    );

    modport slave (
        input  in_valid,
        input  in_state,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_state
    );
endinterface

// File: rtl/sub_bytes_unit.sv
// Time-multiplexed AES SubBytes: LANES S-boxes walk the 16 state bytes in groups
// (byte 0 = MSB byte), one group per cycle, writing results back in place.
module sub_bytes_unit #(
    parameter int LANES = 4
) (
    input  logic                clk,
    input  logic                rst,
    sub_bytes_unit_if.slave     bus,
    output logic                busy,
    output logic [1:0]          state_dbg
);
    localparam int N     = 16 / LANES;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    // FIPS-197 S-box, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [127:0]       work_q, work_d;
    logic [6:0]         byte_msb;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] tidx;
        tidx = 11'(2047 - 8 * int'(x));
        return SBOX_TABLE[tidx -: 8];
    endfunction

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_state = work_q;
    assign busy          = (state_q != IDLE);
    assign state_dbg     = state_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        byte_msb = '0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && bus.in_ready) begin
                    work_d  = bus.in_state;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Group cnt covers bytes cnt*LANES .. cnt*LANES+LANES-1.
                for (int l = 0; l < LANES; l++) begin
                    byte_msb = 7'(127 - 8 * (int'(cnt_q) * LANES + l));
                    work_d[byte_msb -: 8] = sbox(work_q[byte_msb -: 8]);
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                // Work register holds, so out_state is stable while out_valid is high.
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
        end
    end
endmodule

// File: tb/tb_sub_bytes_unit.sv
// Bench for sub_bytes_unit: three instances (LANES = 4, 1, 16) driven by directed
// and random blocks, checked against a GF(2^8) S-box model.
module tb_sub_bytes_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;

    logic         in_valid_r  [3];
    logic [127:0] in_state_r  [3];
    logic         out_ready_r [3];
    logic         in_ready_w  [3];
    logic         out_valid_w [3];
    logic         busy_w      [3];
    logic [127:0] out_state_w [3];
    logic [1:0]   dbg_w       [3];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int acc_n    [3] = '{0, 0, 0};
    int last_acc [3] = '{0, 0, 0};
    int prev_acc [3] = '{0, 0, 0};
    int out_n    [3] = '{0, 0, 0};
    logic [127:0] last_out [3] = '{128'h0, 128'h0, 128'h0};

    localparam logic [127:0] FIPS_IN  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_OUT = 128'h638293c31bfc33f5c4eeacea4bc12816;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sub_bytes_unit_if bus ();
        assign bus.in_valid   = in_valid_r[g];
        assign bus.in_state   = in_state_r[g];
        assign bus.out_ready  = out_ready_r[g];
        assign in_ready_w[g]  = bus.in_ready;
        assign out_valid_w[g] = bus.out_valid;
        assign out_state_w[g] = bus.out_state;
        sub_bytes_unit #(.LANES(g == 0 ? 4 : (g == 1 ? 1 : 16))) u_dut (
            .clk       (clk),
            .rst       (rst),
            .bus       (bus),
            .busy      (busy_w[g]),
            .state_dbg (dbg_w[g])
        );
    end

    // Handshake monitor: records accept edges and delivered results per instance.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int d = 0; d < 3; d++) begin
            if (!rst && in_valid_r[d] && in_ready_w[d]) begin
                acc_n[d]    <= acc_n[d] + 1;
                prev_acc[d] <= last_acc[d];
                last_acc[d] <= cyc;
            end
            if (!rst && out_valid_w[d] && out_ready_r[d]) begin
                out_n[d]    <= out_n[d] + 1;
                last_out[d] <= out_state_w[d];
            end
        end
    end

    function automatic int n_of(input int d);
        return (d == 0) ? 4 : ((d == 1) ? 16 : 1);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from first principles: multiplicative inverse (x^254) then the affine map.
    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_ref(input logic [127:0] st);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[127 - 8 * i -: 8] = sbox_ref(st[127 - 8 * i -: 8]);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic wait_ready(input int d, input string tag);
        int n;
        n = 0;
        while (in_ready_w[d] !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check_bit({tag, "_ready_in_time"}, n < 200, 1'b1);
    endtask

    // One block through instance d; hold > 0 keeps out_ready low that many cycles
    // after out_valid rises while a stray input is offered.
    task automatic send(input int d, input logic [127:0] data, input int hold, input string tag);
        logic [127:0] exp_s;
        int lat, outs0;
        bit run_ok, hold_ok;
        exp_s   = sub_ref(data);
        lat     = 0;
        run_ok  = 1'b1;
        hold_ok = 1'b1;
        out_ready_r[d] = (hold == 0);
        in_state_r[d]  = data;
        in_valid_r[d]  = 1'b1;
        wait_ready(d, tag);
        outs0 = out_n[d];
        step();
        in_valid_r[d] = 1'b0;
        in_state_r[d] = {$urandom, $urandom, $urandom, $urandom};
        while (out_valid_w[d] !== 1'b1 && lat < 64) begin
            if (in_ready_w[d] !== 1'b0 || busy_w[d] !== 1'b1) run_ok = 1'b0;
            step();
            lat++;
        end
        check_int({tag, "_latency"}, lat, n_of(d));
        check_bit({tag, "_run_flags"}, run_ok, 1'b1);
        check_vec({tag, "_result"}, out_state_w[d], exp_s);
        if (hold > 0) begin
            in_valid_r[d] = 1'b1;
            in_state_r[d] = ~data;
            for (int i = 0; i < hold; i++) begin
                step();
                if (out_valid_w[d] !== 1'b1 || out_state_w[d] !== exp_s ||
                    in_ready_w[d] !== 1'b0 || busy_w[d] !== 1'b1) hold_ok = 1'b0;
            end
            check_bit({tag, "_hold_stable"}, hold_ok, 1'b1);
            out_ready_r[d] = 1'b1;
        end
        step();
        check_bit({tag, "_valid_drops"}, out_valid_w[d], 1'b0);
        check_bit({tag, "_idle_after"}, busy_w[d], 1'b0);
        check_bit({tag, "_ready_after"}, in_ready_w[d], 1'b1);
        check_int({tag, "_one_output"}, out_n[d] - outs0, 1);
        in_valid_r[d] = 1'b0;
    endtask

    task automatic b2b(input int d, input logic [127:0] a, input logic [127:0] b, input string tag);
        int acc0, outs0, n;
        acc0  = acc_n[d];
        outs0 = out_n[d];
        n     = 0;
        out_ready_r[d] = 1'b1;
        in_state_r[d]  = a;
        in_valid_r[d]  = 1'b1;
        while (acc_n[d] < acc0 + 2 && n < 200) begin
            step();
            n++;
            if (acc_n[d] == acc0 + 1) in_state_r[d] = b;
        end
        in_valid_r[d] = 1'b0;
        check_int({tag, "_accepts"}, acc_n[d] - acc0, 2);
        check_int({tag, "_period"}, last_acc[d] - prev_acc[d], n_of(d) + 2);
        n = 0;
        while (out_n[d] < outs0 + 2 && n < 200) begin
            step();
            n++;
        end
        check_int({tag, "_outputs"}, out_n[d] - outs0, 2);
        check_vec({tag, "_second_result"}, last_out[d], sub_ref(b));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int outs0;
        bit quiet;
        logic [127:0] r;

        // Reset with input offered: nothing may be captured.
        for (int d = 0; d < 3; d++) begin
            in_valid_r[d]  = 1'b1;
            in_state_r[d]  = FIPS_IN;
            out_ready_r[d] = 1'b1;
        end
        rst = 1'b1;
        repeat (3) step();
        for (int d = 0; d < 3; d++) begin
            check_bit($sformatf("rst_in_ready_%0d", d), in_ready_w[d], 1'b0);
            check_bit($sformatf("rst_out_valid_%0d", d), out_valid_w[d], 1'b0);
            check_bit($sformatf("rst_busy_%0d", d), busy_w[d], 1'b0);
            check_vec($sformatf("rst_out_state_%0d", d), out_state_w[d], 128'h0);
            check_int($sformatf("rst_dbg_idle_%0d", d), int'(dbg_w[d]), 0);
        end
        for (int d = 0; d < 3; d++) in_valid_r[d] = 1'b0;
        rst = 1'b0;
        step();
        for (int d = 0; d < 3; d++) begin
            check_bit($sformatf("post_rst_ready_%0d", d), in_ready_w[d], 1'b1);
            check_bit($sformatf("post_rst_busy_%0d", d), busy_w[d], 1'b0);
        end

        // Known-answer vectors on the 4-lane instance.
        send(0, FIPS_IN, 0, "fips4");
        check_vec("fips4_literal", out_state_w[0], FIPS_OUT);
        send(0, 128'h000102030405060708090a0b0c0d0e0f, 0, "order4");
        check_vec("order4_literal", out_state_w[0], 128'h637c777bf26b6fc53001672bfed7ab76);
        send(0, {16{8'hff}}, 0, "all_ff");
        check_vec("all_ff_literal", out_state_w[0], {16{8'h16}});
        send(0, {16{8'h00}}, 0, "all_00");
        check_vec("all_00_literal", out_state_w[0], {16{8'h63}});

        // Backpressure with a stray input offered in DONE and at the output handshake.
        send(0, {$urandom, $urandom, $urandom, $urandom}, 5, "backpressure");

        // Reset landing on the second RUN edge.
        outs0 = out_n[0];
        out_ready_r[0] = 1'b1;
        in_state_r[0]  = {$urandom, $urandom, $urandom, $urandom};
        in_valid_r[0]  = 1'b1;
        wait_ready(0, "midrst");
        step();
        in_valid_r[0] = 1'b0;
        step();
        rst = 1'b1;
        #1;
        check_bit("midrst_ready_low_1", in_ready_w[1], 1'b0);
        check_bit("midrst_ready_low_2", in_ready_w[2], 1'b0);
        step();
        rst = 1'b0;
        #1;
        check_bit("midrst_valid", out_valid_w[0], 1'b0);
        check_vec("midrst_out_state", out_state_w[0], 128'h0);
        check_bit("midrst_busy", busy_w[0], 1'b0);
        check_bit("midrst_ready", in_ready_w[0], 1'b1);
        quiet = 1'b1;
        repeat (20) begin
            step();
            if (out_valid_w[0] !== 1'b0) quiet = 1'b0;
        end
        check_bit("midrst_no_output", quiet, 1'b1);
        check_int("midrst_out_count", out_n[0] - outs0, 0);
        send(0, {16{8'h00}}, 0, "after_rst");
        check_vec("after_rst_literal", out_state_w[0], {16{8'h63}});

        // Lane-count sweep on the same vector.
        send(1, FIPS_IN, 0, "fips1");
        check_vec("fips1_literal", out_state_w[1], FIPS_OUT);
        send(2, FIPS_IN, 0, "fips16");
        check_vec("fips16_literal", out_state_w[2], FIPS_OUT);

        // Random blocks against the model.
        for (int i = 0; i < 4; i++) begin
            for (int d = 0; d < 3; d++) begin
                r = {$urandom, $urandom, $urandom, $urandom};
                send(d, r, (d == 0 && i == 2) ? int'($urandom_range(1, 4)) : 0,
                     $sformatf("rand_%0d_%0d", d, i));
            end
        end

        // Back-to-back blocks with in_valid held high.
        for (int d = 0; d < 3; d++) begin
            b2b(d, FIPS_IN, {$urandom, $urandom, $urandom, $urandom}, $sformatf("b2b_%0d", d));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sub_bytes_unit.md
# sub_bytes_unit

Sequential AES SubBytes engine. Accepts a 128-bit AES state over a valid/ready handshake and substitutes all 16 bytes through `LANES` parallel `SBox` instances over `16/LANES` cycles. Returns the substituted state over a second valid/ready handshake. Sits between the AddRoundKey/state register and ShiftRows in the round datapath, and time-multiplexes the S-box hardware.

## Interface
- `LANES`, default 4: number of `SBox` instances and bytes substituted per cycle. Legal values are 1, 2, 4, 8, 16. Let N = 16/LANES.
- `clk`  input  1  sole clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  `in_state` holds a block to process.
- `in_ready`  output  1  block can accept input this cycle.
- `in_state`  input  128  input AES state.
- `out_valid`  output  1  `out_state` holds a finished result.
- `out_ready`  input  1  downstream accepts the result this cycle.
- `out_state`  output  128  substituted AES state.
- `busy`  output  1  high while a block is held (RUN or DONE).

## Operation
- **Byte order.** Byte i (i = 0..15) is `state[127-8i -: 8]`, so byte 0 is the MSB byte (FIPS-197 input order).
- **Processing order.** Group g covers bytes g·LANES .. g·LANES+LANES-1. Groups are processed in order 0..N-1.
- **Storage.**
  - One 128-bit work register (`out_state` drives directly from it).
  - A group counter `cnt`, 0..N-1, width max(1, log2 N).
  - A 2-bit FSM.
- **FSM states:**
  - **IDLE**
    - `in_ready`=1.
    - On `in_valid` & `in_ready`: work ← `in_state`, `cnt` ← 0, go to RUN.
  - **RUN**
    - Each cycle, group `cnt` of the work register goes through the S-boxes, and the results are written back to the same byte positions. Other bytes hold.
    - If `cnt`==N-1, go to DONE. Otherwise `cnt` ← `cnt`+1.
  - **DONE**
    - `out_valid`=1.
    - On `out_ready`, go to IDLE. The work register keeps its value.
- **Input sampling.** `in_state` is sampled only on the accept edge. Later changes are ignored.
- **Ready outside IDLE.** `in_ready`=0 in RUN and DONE. `in_valid` in those states is ignored, and the block does not capture it.
- **Busy.** `busy` = (FSM ≠ IDLE).
- **Output stability.** `out_state` must not change while `out_valid`=1, regardless of `out_ready`.
- **Downstream datapath.** The S-box is purely combinational, so the RUN datapath is one level: register → `SBox` → register. No pipelining.

## Timing
- **Reset values** (on any rising edge with `rst`=1, taking priority over all else):
  - FSM = IDLE, `cnt` = 0, work register = 0.
  - `out_valid`=0, `busy`=0, `out_state`=0.
  - `in_ready`=0 while `rst` is high, and 1 from the first cycle after `rst` falls.
- **Latency.** If input is accepted at edge k, groups 0..N-1 are written at edges k+1..k+N. FSM enters DONE at edge k+N, so `out_valid` is high from edge k+N. That is 4 cycles for `LANES`=4 and 16 cycles for `LANES`=1.
- **Throughput.** After an output handshake at edge m, the FSM is in IDLE. The earliest next accept is edge m+1, giving a minimum period of N+2 cycles per block.
- **Reset mid-operation.** `rst` in RUN or DONE aborts the block:
  - no `out_valid` pulse is produced for it;
  - `out_valid` is low from the next edge;
  - the block is back in IDLE one cycle after `rst` deasserts.
- **Simultaneous events.**
  - `rst` together with `in_valid` or `out_ready`: reset wins, and no handshake completes.
  - In DONE with `out_ready`=1 and `in_valid`=1: only the output handshake completes; the input is not accepted that cycle.
- **Backpressure.** DONE is held indefinitely while `out_ready`=0.
- **Counter wrap.** `cnt` never exceeds N-1 and is reset to 0 on every accept.

## Test plan
- **FIPS-197 vector** (`LANES`=4): accept `in_state`=00112233445566778899aabbccddeeff at edge k, with `out_ready`=1.
  - `out_valid` rises at edge k+4.
  - `out_state`=638293c31bfc33f5c4eeacea4bc12816.
  - `in_ready` is low at edges k+1..k+5.
- **Ordering and table check:**
  - `in_state`=000102030405060708090a0b0c0d0e0f → `out_state`=637c777bf26b6fc53001672bfed7ab76.
  - All-ff input → all-16 output.
  - All-00 input → all-63 output.
- **Backpressure:** hold `out_ready`=0 for 5 cycles after `out_valid` rises.
  - `out_valid` stays 1, `out_state` stays constant, `in_ready`=0, `busy`=1.
  - When `out_ready`=1, a single handshake completes, then IDLE with `in_ready`=1.
  - Change `in_state` during RUN: the output is unaffected.
- **Reset mid-run:** assert `rst` for 1 cycle at the second RUN edge.
  - No `out_valid` is produced; `out_state` reads 0.
  - A new block (all-00) accepted afterwards yields all-63 with normal latency.
- **Parameter sweep** `LANES` ∈ {1, 16} with the FIPS-197 vector:
  - latency is 16 and 1 cycles respectively;
  - results are identical to the `LANES`=4 case;
  - back-to-back blocks with `in_valid` held high achieve a period of N+2.
